// File: rtl/btn_event_decoder.sv
// ---------------------------------------------------------------------------
// btn_event_decoder
//
// Turns a clean, debounced button level into gesture events: short click,
// double click, long press, auto-repeat while held, and long-press release.
// Events leave through a 1-deep holding register.
//
// Handshake: an event is presented while ev_valid=1 and is consumed on a clk
// edge where ev_valid & ev_ready. While ev_valid=1 and ev_ready=0, ev_code
// holds steady. An event generated in that situation is lost and flagged on
// the sticky ev_drop.
//
// Ports
//   clk       in   system clock
//   n_reset   in   asynchronous reset, active-low
//   btn_in    in   debounced button level (1 = pressed), synchronous to clk
//   pressed   out  registered copy of btn_in
//   ev_valid  out  event available
//   ev_code   out  1=SHORT 2=DOUBLE 3=LONG 4=REPEAT 5=LONG_REL, 0 when idle
//   ev_ready  in   consumer accepts the event
//   ev_drop   out  sticky flag: an event was lost because the register was full
//   drop_clr  in   clears ev_drop; a new drop in the same cycle wins
// ---------------------------------------------------------------------------
module btn_event_decoder #(
    parameter int CNT_W      = 28,
    parameter int LONG_CYC   = 50_000_000,
    parameter int DCLICK_CYC = 25_000_000,
    parameter int REPEAT_CYC = 10_000_000,
    parameter bit REPEAT_EN  = 1'b1
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       btn_in,
    output logic       pressed,
    output logic       ev_valid,
    output logic [2:0] ev_code,
    input  logic       ev_ready,
    output logic       ev_drop,
    input  logic       drop_clr
);

    localparam logic [2:0] EV_NONE     = 3'd0;
    localparam logic [2:0] EV_SHORT    = 3'd1;
    localparam logic [2:0] EV_DOUBLE   = 3'd2;
    localparam logic [2:0] EV_LONG     = 3'd3;
    localparam logic [2:0] EV_REPEAT   = 3'd4;
    localparam logic [2:0] EV_LONG_REL = 3'd5;

    // A timeout fires on the edge where cnt reaches limit-1, so cnt never
    // has to count past these values.
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYC - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESSED,
        S_WAIT2,
        S_PRESSED2,
        S_HELD
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             btn_q;
    logic             armed;
    logic             rise;
    logic             fall;
    logic             cnt_clr;
    logic             emit;
    logic [2:0]       emit_code;

    assign rise    = btn_in & ~btn_q;
    assign fall    = ~btn_in & btn_q;
    assign pressed = btn_q;

    // Next-state and event decode. A button edge is always tested before
    // the timeout, so the edge wins when both occur on the same clk edge.
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        emit      = 1'b0;
        emit_code = EV_NONE;
        case (state)
            S_IDLE: begin
                cnt_clr = 1'b1;
                // armed blocks a button that is already down at reset
                // release from being seen as a fresh press.
                if (rise && armed) begin
                    state_nxt = S_PRESSED;
                end
            end
            S_PRESSED: begin
                if (fall) begin
                    state_nxt = S_WAIT2;
                    cnt_clr   = 1'b1;
                end else if (cnt == LONG_LAST) begin
                    state_nxt = S_HELD;
                    cnt_clr   = 1'b1;
                    emit      = 1'b1;
                    emit_code = EV_LONG;
                end
            end
            S_WAIT2: begin
                if (rise) begin
                    state_nxt = S_PRESSED2;
                    cnt_clr   = 1'b1;
                end else if (cnt == DCLICK_LAST) begin
                    state_nxt = S_IDLE;
                    cnt_clr   = 1'b1;
                    emit      = 1'b1;
                    emit_code = EV_SHORT;
                end
            end
            S_PRESSED2: begin
                if (fall) begin
                    state_nxt = S_IDLE;
                    cnt_clr   = 1'b1;
                    emit      = 1'b1;
                    emit_code = EV_DOUBLE;
                end else if (cnt == LONG_LAST) begin
                    // The first click is swallowed; this becomes a long press.
                    state_nxt = S_HELD;
                    cnt_clr   = 1'b1;
                    emit      = 1'b1;
                    emit_code = EV_LONG;
                end
            end
            S_HELD: begin
                if (fall) begin
                    state_nxt = S_IDLE;
                    cnt_clr   = 1'b1;
                    emit      = 1'b1;
                    emit_code = EV_LONG_REL;
                end else if (!REPEAT_EN) begin
                    // Nothing is timed here without repeat; park the counter.
                    cnt_clr = 1'b1;
                end else if (cnt == REPEAT_LAST) begin
                    cnt_clr   = 1'b1;
                    emit      = 1'b1;
                    emit_code = EV_REPEAT;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_clr   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            btn_q    <= 1'b0;
            armed    <= 1'b0;
            ev_valid <= 1'b0;
            ev_code  <= EV_NONE;
            ev_drop  <= 1'b0;
        end else begin
            btn_q <= btn_in;
            armed <= armed | ~btn_in;
            state <= state_nxt;
            cnt   <= cnt_clr ? '0 : cnt + 1'b1;

            // Holding register: load when empty or being drained this edge,
            // otherwise drop the new event and keep the held one.
            if (emit) begin
                if (!ev_valid || ev_ready) begin
                    ev_valid <= 1'b1;
                    ev_code  <= emit_code;
                end
            end else if (ev_valid && ev_ready) begin
                ev_valid <= 1'b0;
                ev_code  <= EV_NONE;
            end

            if (emit && ev_valid && !ev_ready) begin
                ev_drop <= 1'b1;
            end else if (drop_clr) begin
                ev_drop <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_btn_event_decoder.sv
module tb_btn_event_decoder;

    logic       clk;
    logic       n_reset;
    logic       btn_in;
    logic       pressed;
    logic       ev_valid;
    logic [2:0] ev_code;
    logic       ev_ready;
    logic       ev_drop;
    logic       drop_clr;

    int n_vec;
    int n_err;

    btn_event_decoder #(
        .CNT_W      (28),
        .LONG_CYC   (20),
        .DCLICK_CYC (10),
        .REPEAT_CYC (5),
        .REPEAT_EN  (1'b1)
    ) dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .btn_in   (btn_in),
        .pressed  (pressed),
        .ev_valid (ev_valid),
        .ev_code  (ev_code),
        .ev_ready (ev_ready),
        .ev_drop  (ev_drop),
        .drop_clr (drop_clr)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive btn_in for one clk edge, then check the outputs 1 time unit later.
    task automatic cyc(input logic b, input logic v, input logic [2:0] c, input string tag);
        btn_in = b;
        @(posedge clk);
        #1;
        chk({tag, " pressed"}, {7'd0, pressed}, {7'd0, b});
        chk({tag, " ev_valid"}, {7'd0, ev_valid}, {7'd0, v});
        chk({tag, " ev_code"}, {5'd0, ev_code}, {5'd0, c});
    endtask

    task automatic cyc_n(input int n, input logic b, input logic v, input logic [2:0] c,
                         input string tag);
        for (int i = 0; i < n; i++) cyc(b, v, c, tag);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " pressed"}, {7'd0, pressed}, 8'd0);
        chk({tag, " ev_valid"}, {7'd0, ev_valid}, 8'd0);
        chk({tag, " ev_code"}, {5'd0, ev_code}, 8'd0);
        chk({tag, " ev_drop"}, {7'd0, ev_drop}, 8'd0);
    endtask

    initial begin
        logic [2:0] c;
        n_vec    = 0;
        n_err    = 0;
        n_reset  = 1'b0;
        btn_in   = 1'b0;
        ev_ready = 1'b1;
        drop_clr = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        n_reset = 1'b1;
        cyc_n(3, 1'b0, 1'b0, 3'd0, "idle0");

        // 1: single click -> SHORT 10 edges after the fall edge
        cyc_n(5, 1'b1, 1'b0, 3'd0, "t1 hold");
        cyc_n(10, 1'b0, 1'b0, 3'd0, "t1 wait");
        cyc(1'b0, 1'b1, 3'd1, "t1 short");
        cyc_n(4, 1'b0, 1'b0, 3'd0, "t1 idle");

        // 2: double click -> DOUBLE on second fall, no SHORT afterwards
        cyc_n(5, 1'b1, 1'b0, 3'd0, "t2 hold1");
        cyc_n(4, 1'b0, 1'b0, 3'd0, "t2 gap");
        cyc_n(5, 1'b1, 1'b0, 3'd0, "t2 hold2");
        cyc(1'b0, 1'b1, 3'd2, "t2 double");
        cyc_n(12, 1'b0, 1'b0, 3'd0, "t2 idle");

        // 3: long hold -> LONG at 20, REPEAT at 25 and 30, LONG_REL at fall
        for (int i = 0; i < 32; i++) begin
            if (i == 20)                c = 3'd3;
            else if (i == 25 || i == 30) c = 3'd4;
            else                        c = 3'd0;
            cyc(1'b1, c != 3'd0, c, "t3 hold");
        end
        cyc(1'b0, 1'b1, 3'd5, "t3 long_rel");
        cyc_n(4, 1'b0, 1'b0, 3'd0, "t3 idle");

        // 4: consumer stalled -> first SHORT held, second dropped
        ev_ready = 1'b0;
        cyc_n(5, 1'b1, 1'b0, 3'd0, "t4 hold1");
        cyc_n(10, 1'b0, 1'b0, 3'd0, "t4 wait1");
        cyc(1'b0, 1'b1, 3'd1, "t4 short1");
        cyc_n(14, 1'b0, 1'b1, 3'd1, "t4 held");
        cyc_n(5, 1'b1, 1'b1, 3'd1, "t4 hold2");
        cyc_n(10, 1'b0, 1'b1, 3'd1, "t4 wait2");
        chk("t4 no drop yet", {7'd0, ev_drop}, 8'd0);
        cyc(1'b0, 1'b1, 3'd1, "t4 short2");
        chk("t4 drop set", {7'd0, ev_drop}, 8'd1);
        cyc(1'b0, 1'b1, 3'd1, "t4 sticky");
        chk("t4 drop sticky", {7'd0, ev_drop}, 8'd1);
        drop_clr = 1'b1;
        cyc(1'b0, 1'b1, 3'd1, "t4 clr");
        drop_clr = 1'b0;
        chk("t4 drop clr", {7'd0, ev_drop}, 8'd0);
        ev_ready = 1'b1;
        cyc(1'b0, 1'b0, 3'd0, "t4 drain");
        cyc_n(2, 1'b0, 1'b0, 3'd0, "t4 idle");

        // 5: reset mid-press, button kept down -> no events afterwards
        cyc_n(10, 1'b1, 1'b0, 3'd0, "t5 hold");
        n_reset = 1'b0;
        #1;
        chk_all_zero("t5 async");
        @(posedge clk);
        #1;
        chk_all_zero("t5 in reset");
        n_reset = 1'b1;
        cyc_n(30, 1'b1, 1'b0, 3'd0, "t5 held");
        cyc_n(3, 1'b0, 1'b0, 3'd0, "t5 release");

        // 6: re-press on the WAIT2 timeout edge -> edge wins, DOUBLE later
        cyc_n(5, 1'b1, 1'b0, 3'd0, "t6 hold1");
        cyc_n(10, 1'b0, 1'b0, 3'd0, "t6 wait");
        cyc(1'b1, 1'b0, 3'd0, "t6 repress");
        cyc_n(4, 1'b1, 1'b0, 3'd0, "t6 hold2");
        cyc(1'b0, 1'b1, 3'd2, "t6 double");
        cyc_n(12, 1'b0, 1'b0, 3'd0, "t6 idle");
        chk("final drop", {7'd0, ev_drop}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
